// File: rtl/fft_engine.sv
// Iterative in-place radix-2 DIT FFT/IFFT engine: bit-reversed load, one
// butterfly per cycle, natural-order unload with valid/ready on both sides.
module fft_engine #(
  parameter int DATA_W  = 32,
  parameter int LOG2N   = 3,
  parameter int TW_FRAC = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int N      = 1 << LOG2N;
  localparam int COEF_W = 16;
  localparam int STAGES = LOG2N;
  localparam int PW     = 2 * DATA_W + 2;
  localparam int W_W    = LOG2N + 1;
  localparam int B_W    = LOG2N;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W_W-1:0] word_cnt;
  logic [W_W-1:0] out_cnt;
  logic [B_W-1:0] bfly_cnt;
  logic [1:0]     stage_cnt;
  logic           mode;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  logic           load_fire;
  logic           load_done;
  logic           bfly_last;
  logic           stage_last;
  logic           unload_fire;
  logic           unload_done;
  logic [B_W-1:0] load_addr;

  function automatic logic [B_W-1:0] bitrev(input logic [B_W-1:0] k);
    logic [B_W-1:0] r;
    for (int i = 0; i < B_W; i++) r[i] = k[B_W-1-i];
    return r;
  endfunction

  function automatic logic signed [COEF_W-1:0] tw_cos(input logic [2:0] m);
    case (m)
      3'd0:    return 16'sd16384;
      3'd1:    return 16'sd15137;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd6270;
      3'd4:    return 16'sd0;
      3'd5:    return -16'sd6270;
      3'd6:    return -16'sd11585;
      default: return -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [COEF_W-1:0] tw_sin(input logic [2:0] m);
    case (m)
      3'd0:    return 16'sd0;
      3'd1:    return 16'sd6270;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd15137;
      3'd4:    return 16'sd16384;
      3'd5:    return 16'sd15137;
      3'd6:    return 16'sd11585;
      default: return 16'sd6270;
    endcase
  endfunction

  // (a*c + b*s) at full precision, floor-shifted out of Q1.14, truncated
  function automatic logic signed [DATA_W-1:0] rot(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [COEF_W-1:0] c,
    input logic signed [COEF_W-1:0] s
  );
    logic signed [PW-1:0] acc;
    acc = PW'(a) * PW'(c) + PW'(b) * PW'(s);
    acc = acc >>> TW_FRAC;
    return acc[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] scale(
    input logic signed [DATA_W-1:0] v,
    input logic                     half
  );
    return half ? (v >>> 1) : v;
  endfunction

  // Butterfly addressing and arithmetic for the current (stage, butterfly)
  logic [B_W-1:0] span, pos, top_idx, bot_idx;
  logic [2:0]     tw_m;
  logic signed [COEF_W-1:0] tw_c, tw_s;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  always_comb begin
    span    = B_W'(1) << stage_cnt;
    pos     = bfly_cnt & (span - B_W'(1));
    top_idx = ((bfly_cnt & ~(span - B_W'(1))) << 1) + pos;
    bot_idx = top_idx + span;
    tw_m    = 3'(pos) << (2'd3 - stage_cnt);
    tw_c    = tw_cos(tw_m);
    tw_s    = mode ? -tw_sin(tw_m) : tw_sin(tw_m);
    a_re    = mem_re[top_idx];
    a_im    = mem_im[top_idx];
    b_re    = mem_re[bot_idx];
    b_im    = mem_im[bot_idx];
    t_re    = rot(b_re, b_im, tw_c, tw_s);
    t_im    = rot(b_im, b_re, tw_c, -tw_s);
    top_re  = scale(a_re + t_re, mode);
    top_im  = scale(a_im + t_im, mode);
    bot_re  = scale(a_re - t_re, mode);
    bot_im  = scale(a_im - t_im, mode);
  end

  assign load_addr   = bitrev(word_cnt[W_W-1:1]);
  assign load_fire   = (state == LOAD) && in_valid;
  assign load_done   = load_fire && (word_cnt == W_W'(2 * N - 1));
  assign bfly_last   = (bfly_cnt == B_W'(N / 2 - 1));
  assign stage_last  = (stage_cnt == 2'(STAGES - 1));
  assign unload_fire = (state == UNLOAD) && out_ready;
  assign unload_done = unload_fire && (out_cnt == W_W'(2 * N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    out_data   = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_done) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (bfly_last && stage_last) state_next = UNLOAD;
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (out_cnt == W_W'(2 * N - 1));
        out_data  = out_cnt[0] ? mem_im[out_cnt[W_W-1:1]] : mem_re[out_cnt[W_W-1:1]];
        if (unload_done) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      out_cnt   <= '0;
      bfly_cnt  <= '0;
      stage_cnt <= '0;
      mode      <= 1'b0;
    end else begin
      if (load_fire) begin
        word_cnt <= word_cnt + W_W'(1);
        if (word_cnt == '0) mode <= in_mode;
      end
      if (state == COMPUTE) begin
        if (bfly_last) begin
          bfly_cnt  <= '0;
          stage_cnt <= stage_last ? 2'd0 : stage_cnt + 2'd1;
        end else begin
          bfly_cnt <= bfly_cnt + B_W'(1);
        end
      end
      if (unload_fire) out_cnt <= out_cnt + W_W'(1);
    end
  end

  // Sample storage: load writes in bit-reversed order, compute writes back in place
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (word_cnt[0]) mem_im[load_addr] <= $signed(in_data);
      else             mem_re[load_addr] <= $signed(in_data);
    end else if (state == COMPUTE) begin
      mem_re[top_idx] <= top_re;
      mem_im[top_idx] <= top_im;
      mem_re[bot_idx] <= bot_re;
      mem_im[bot_idx] <= bot_im;
    end
  end

endmodule
